// File: rtl/commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buf
// Description : Commit-event recorder for the 5-stage pipeline. Each cycle the
//               register write / load / store / halt commits are turned into
//               fixed-format records (up to 3 per cycle), captured
//               all-or-nothing into a FIFO and drained over a valid/ready
//               stream. Provides backpressure (trace_full), sticky overflow,
//               a saturating drop counter and a drained flag after halt.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   RegWrite/WriteRegister/WriteData              : register write commit
//   MemRead/MemWrite/MemAddress/MemDataIn/MemDataOut : load/store commit
//   Halt, PC                 : halt commit, PC of committing instruction
//   out_valid/out_ready      : head record stream handshake
//   out_type/out_addr/out_data/out_pc : head record fields (0 while empty)
//   trace_full               : fewer than 3 free entries
//   overflow, drop_count     : sticky drop flag, saturating dropped-cycle count
//   drained                  : halted and FIFO empty
// Configuration macro:
//   COMMIT_TRACE_PC_EN       : store a PC per entry and present it on out_pc;
//                              when undefined out_pc is tied to zero.
// ============================================================================
module commit_trace_buf #(
    parameter int DEPTH = 16,
    parameter int PTR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWrite,
    input  logic [2:0]  WriteRegister,
    input  logic [15:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [15:0] MemAddress,
    input  logic [15:0] MemDataIn,
    input  logic [15:0] MemDataOut,
    input  logic        Halt,
    input  logic [15:0] PC,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:0]  out_type,
    output logic [15:0] out_addr,
    output logic [15:0] out_data,
    output logic [15:0] out_pc,
    output logic        trace_full,
    output logic        overflow,
    output logic [7:0]  drop_count,
    output logic        drained
);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } state_t;

    localparam logic [1:0]     c_TYPE_REG   = 2'b00;
    localparam logic [1:0]     c_TYPE_LOAD  = 2'b01;
    localparam logic [1:0]     c_TYPE_STORE = 2'b10;
    localparam logic [1:0]     c_TYPE_HALT  = 2'b11;
    localparam logic [PTR_W:0] c_DEPTH      = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] c_FULL_THR   = (PTR_W+1)'(3);

    state_t             r_state, w_state_next;
    logic [PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_trace_full, r_overflow, r_drained;
    logic [7:0]         r_drop_count;

    logic [1:0]         r_mem_type [DEPTH];
    logic [15:0]        r_mem_addr [DEPTH];
    logic [15:0]        r_mem_data [DEPTH];

    logic               w_has_reg, w_has_mem, w_has_halt;
    logic [1:0]         w_n;
    logic [PTR_W:0]     w_free, w_count_next;
    logic               w_push, w_drop, w_pop;
    logic [PTR_W-1:0]   w_mem_idx, w_halt_idx;
    logic [1:0]         w_mem_type;
    logic [15:0]        w_mem_data;

    // Event decode, all-or-nothing admission and occupancy update. Free space
    // uses the start-of-cycle occupancy, so a same-cycle pop never helps.
    always_comb begin
        w_has_reg    = (r_state == ST_RUN) && RegWrite;
        w_has_mem    = (r_state == ST_RUN) && (MemRead || MemWrite);
        w_has_halt   = (r_state == ST_RUN) && Halt;
        w_n          = {1'b0, w_has_reg} + {1'b0, w_has_mem} + {1'b0, w_has_halt};
        w_free       = c_DEPTH - r_count;
        w_push       = (w_n != 2'd0) && (w_free >= {{(PTR_W-1){1'b0}}, w_n});
        w_drop       = (w_n != 2'd0) && !w_push;
        w_pop        = (r_count != '0) && out_ready;
        w_count_next = r_count
                     + (w_push ? {{(PTR_W-1){1'b0}}, w_n} : '0)
                     - {{PTR_W{1'b0}}, w_pop};
        // Records pack densely in REG, LOAD/STORE, HALT order.
        w_mem_idx    = r_wr_ptr + PTR_W'(w_has_reg);
        w_halt_idx   = r_wr_ptr + PTR_W'({1'b0, w_has_reg} + {1'b0, w_has_mem});
        // A simultaneous load and store is recorded as the store only.
        w_mem_type   = MemWrite ? c_TYPE_STORE : c_TYPE_LOAD;
        w_mem_data   = MemWrite ? MemDataIn : MemDataOut;
    end

    // Halt moves to HALTED even when the halt cycle's records are dropped.
    always_comb begin
        w_state_next = r_state;
        if (w_has_halt) begin
            w_state_next = ST_HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_trace_full <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= 8'd0;
            r_drained    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_wr_ptr     <= r_wr_ptr + (w_push ? PTR_W'(w_n) : '0);
            r_rd_ptr     <= r_rd_ptr + PTR_W'(w_pop);
            r_count      <= w_count_next;
            r_trace_full <= (c_DEPTH - w_count_next) < c_FULL_THR;
            r_overflow   <= r_overflow || w_drop;
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
            r_drained    <= (w_state_next == ST_HALTED) && (w_count_next == '0);
        end
    end

    // Storage carries no reset; stale contents are masked by occupancy.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            if (w_has_reg) begin
                r_mem_type[r_wr_ptr] <= c_TYPE_REG;
                r_mem_addr[r_wr_ptr] <= {13'd0, WriteRegister};
                r_mem_data[r_wr_ptr] <= WriteData;
            end
            if (w_has_mem) begin
                r_mem_type[w_mem_idx] <= w_mem_type;
                r_mem_addr[w_mem_idx] <= MemAddress;
                r_mem_data[w_mem_idx] <= w_mem_data;
            end
            if (w_has_halt) begin
                r_mem_type[w_halt_idx] <= c_TYPE_HALT;
                r_mem_addr[w_halt_idx] <= 16'd0;
                r_mem_data[w_halt_idx] <= 16'd0;
            end
        end
    end

    assign out_valid  = (r_count != '0);
    assign out_type   = out_valid ? r_mem_type[r_rd_ptr] : 2'b00;
    assign out_addr   = out_valid ? r_mem_addr[r_rd_ptr] : 16'd0;
    assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : 16'd0;
    assign trace_full = r_trace_full;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign drained    = r_drained;

`ifdef COMMIT_TRACE_PC_EN
    logic [15:0] r_mem_pc [DEPTH];

    // Every record of a cycle carries that cycle's PC.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            if (w_has_reg) begin
                r_mem_pc[r_wr_ptr] <= PC;
            end
            if (w_has_mem) begin
                r_mem_pc[w_mem_idx] <= PC;
            end
            if (w_has_halt) begin
                r_mem_pc[w_halt_idx] <= PC;
            end
        end
    end

    assign out_pc = out_valid ? r_mem_pc[r_rd_ptr] : 16'd0;
`else
    logic w_pc_unused;
    assign w_pc_unused = ^PC;
    assign out_pc      = 16'h0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buf
// Description : Scoreboard bench for commit_trace_buf. A stimulus process
//               drives one cycle at a time and applies each cycle's events to
//               a queue-based reference model; a monitor on the falling edge
//               compares the head record and status flags against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_commit_trace_buf;

    localparam int DEPTH = 16;
    localparam int PTR_W = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite, MemRead, MemWrite, Halt, out_ready;
    logic [2:0]  WriteRegister;
    logic [15:0] WriteData, MemAddress, MemDataIn, MemDataOut, PC;
    logic        out_valid, trace_full, overflow, drained;
    logic [1:0]  out_type;
    logic [15:0] out_addr, out_data, out_pc;
    logic [7:0]  drop_count;

    always #5 clk = ~clk;

    commit_trace_buf #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst),
        .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemAddress(MemAddress),
        .MemDataIn(MemDataIn), .MemDataOut(MemDataOut),
        .Halt(Halt), .PC(PC),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_type(out_type), .out_addr(out_addr), .out_data(out_data), .out_pc(out_pc),
        .trace_full(trace_full), .overflow(overflow),
        .drop_count(drop_count), .drained(drained)
    );

    typedef struct {
        logic [1:0]  t;
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] pc;
    } rec_t;

    rec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state (after the most recent edge) and the snapshot
    // the monitor compares against during the current cycle.
    bit   m_halted = 1'b0;
    bit   m_ovf    = 1'b0;
    int   m_drops  = 0;
    int   s_occ    = 0;
    bit   s_full, s_ovf, s_drained;
    int   s_drop;
    bit   mon_en   = 1'b0;
    rec_t hd;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_pc(input logic [15:0] pc);
`ifdef COMMIT_TRACE_PC_EN
        return pc;
`else
        return 16'h0000 & pc;
`endif
    endfunction

    // One cycle: snapshot the model, drive the inputs, apply the events.
    task automatic drive(input bit rw, input bit [2:0] wr, input bit [15:0] wd,
                         input bit mr, input bit mw, input bit [15:0] ma,
                         input bit [15:0] mdi, input bit [15:0] mdo,
                         input bit h, input bit [15:0] pc, input bit rdy, input bit rs);
        rec_t recs[$];
        rec_t r;
        @(posedge clk);
        #1;
        s_occ     = exp_q.size();
        s_full    = (DEPTH - s_occ) < 3;
        s_ovf     = m_ovf;
        s_drop    = m_drops;
        s_drained = m_halted && (s_occ == 0);
        rst = rs; RegWrite = rw; WriteRegister = wr; WriteData = wd;
        MemRead = mr; MemWrite = mw; MemAddress = ma; MemDataIn = mdi;
        MemDataOut = mdo; Halt = h; PC = pc; out_ready = rdy;
        if (rs) begin
            exp_q.delete();
            m_halted = 1'b0;
            m_ovf    = 1'b0;
            m_drops  = 0;
        end else if (!m_halted) begin
            if (rw) begin
                r.t = 2'b00; r.a = {13'd0, wr}; r.d = wd; r.pc = exp_pc(pc);
                recs.push_back(r);
            end
            if (mw) begin
                r.t = 2'b10; r.a = ma; r.d = mdi; r.pc = exp_pc(pc);
                recs.push_back(r);
            end else if (mr) begin
                r.t = 2'b01; r.a = ma; r.d = mdo; r.pc = exp_pc(pc);
                recs.push_back(r);
            end
            if (h) begin
                r.t = 2'b11; r.a = 16'd0; r.d = 16'd0; r.pc = exp_pc(pc);
                recs.push_back(r);
            end
            if (recs.size() > 0) begin
                if (DEPTH - s_occ >= recs.size()) begin
                    foreach (recs[i]) exp_q.push_back(recs[i]);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drops < 255) m_drops++;
                end
            end
            if (h) m_halted = 1'b1;
        end
    endtask

    task automatic idle(input bit rdy);
        drive(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 0, 16'd0, rdy, 0);
    endtask

    task automatic store(input bit [15:0] a, input bit [15:0] d, input bit rdy);
        drive(0, 3'd0, 16'd0, 0, 1, a, d, 16'd0, 0, a ^ 16'h0100, rdy, 0);
    endtask

    task automatic do_reset();
        drive(0, 3'd0, 16'd0, 0, 0, 16'd0, 16'd0, 16'd0, 0, 16'd0, 0, 1);
    endtask

    task automatic rand_cycle(input int rdy_pct);
        bit rs;
        rs = (m_halted && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 499) == 0);
        drive($urandom_range(0, 1), 3'($urandom), 16'($urandom),
              $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
              16'($urandom), 16'($urandom), 16'($urandom),
              $urandom_range(0, 99) == 0, 16'($urandom),
              $urandom_range(0, 99) < rdy_pct, rs);
    endtask

    // Monitor: compares the DUT against the snapshot for the current cycle
    // and retires the head record when the handshake will complete.
    always @(negedge clk) begin
        if (mon_en) begin
            check("trace_full", trace_full, s_full);
            check("overflow", overflow, s_ovf);
            check("drop_count", drop_count, s_drop);
            check("drained", drained, s_drained);
            if (!rst) begin
                check("out_valid", out_valid, s_occ != 0);
                if (s_occ != 0) begin
                    hd = exp_q[0];
                    check("out_type", out_type, hd.t);
                    check("out_addr", out_addr, hd.a);
                    check("out_data", out_data, hd.d);
                    check("out_pc", out_pc, hd.pc);
                    if (out_ready) void'(exp_q.pop_front());
                end else begin
                    check("empty_head", {out_type, out_addr, out_data, out_pc}, 64'd0);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; RegWrite = 0; WriteRegister = 0; WriteData = 0; MemRead = 0;
        MemWrite = 0; MemAddress = 0; MemDataIn = 0; MemDataOut = 0; Halt = 0;
        PC = 0; out_ready = 0;
        do_reset();
        do_reset();
        mon_en = 1'b1;

        // Single register write, consumer always ready.
        drive(1, 3'd3, 16'h00A5, 0, 0, 16'd0, 16'd0, 16'd0, 0, 16'h0010, 1, 0);
        for (int i = 0; i < 3; i++) idle(1);

        // Store PC capture.
        store(16'h0080, 16'hBEEF, 0);
        drive(0, 3'd0, 16'd0, 0, 1, 16'h0090, 16'h1234, 16'd0, 0, 16'h0026, 0, 0);
        for (int i = 0; i < 3; i++) idle(1);

        // Fill to 14, then a 3-record cycle is dropped (and halts).
        for (int i = 0; i < 14; i++) store(16'(i), 16'(16'hA000 + i), 0);
        drive(1, 3'd2, 16'h5555, 0, 1, 16'h0F00, 16'h6666, 16'd0, 1, 16'h0030, 0, 0);
        check("full_at_14", trace_full, 1'b1);
        idle(0);
        check("drop_after_3rec", {overflow, drop_count}, {1'b1, 8'd1});
        do_reset();

        // Fill to 16; pop plus REG in the same cycle drops the REG.
        for (int i = 0; i < 16; i++) store(16'(16'h0200 + i), 16'($urandom), 0);
        drive(1, 3'd5, 16'h7777, 0, 0, 16'd0, 16'd0, 16'd0, 0, 16'd0, 1, 0);
        idle(0);
        check("ovf_full_pop", overflow, 1'b1);

        // Saturate the drop counter.
        for (int i = 0; i < 300; i++) store(16'(i), 16'(i), 0);
        idle(0);
        check("drop_sat", drop_count, 8'd255);

        // Wrap pointers with sustained push/pop traffic.
        for (int i = 0; i < 40; i++) store(16'(16'h0400 + i), 16'($urandom), 1);

        // Reset mid-drain.
        do_reset();
        idle(1);
        check("post_rst", {out_valid, overflow, drop_count}, 10'd0);

        // Multi-record halt cycle; later events ignored; drained after pops.
        drive(1, 3'd1, 16'h1111, 1, 0, 16'h0040, 16'd0, 16'h2222, 1, 16'h0050, 1, 0);
        for (int i = 0; i < 8; i++) rand_cycle(100);
        check("drained_after_halt", drained, m_halted ? 1'b1 : 1'b0);
        do_reset();

        // Randomized traffic with varying consumer throughput.
        for (int seg = 0; seg < 15; seg++) begin
            int pct;
            pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 50 : 90);
            for (int i = 0; i < 200; i++) rand_cycle(pct);
        end

        // Drain everything.
        for (int i = 0; i < DEPTH + 4; i++) idle(1);
        check("final_empty", exp_q.size(), 0);
        mon_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
